// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op codes, FSM states,
// big-endian lane masks and op classification.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // Big-endian: byte offset 0 lives in the most significant lane.
    localparam logic [31:0] LANE0_MASK   = 32'hFF00_0000;
    localparam logic [31:0] HALF_HI_MASK = 32'hFFFF_0000;
    localparam logic [31:0] HALF_LO_MASK = 32'h0000_FFFF;

    function automatic logic [31:0] lane_mask(input logic [1:0] k);
        return LANE0_MASK >> {k, 3'b000};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response channel of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_lane_merge.sv
// Pure datapath: extracts/extends load results and merges sub-word store data
// into a memory word, keeping the FSM free of lane arithmetic.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  sh_left;
    logic [4:0]  sh_right;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] bmask;
    logic [31:0] hmask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sh_left    = {offset, 3'b000};
        sh_right   = {~offset, 3'b000};
        byte_val   = 8'(word >> sh_right);
        half_val   = offset[1] ? word[15:0] : word[31:16];
        bmask      = lane_mask(offset);
        hmask      = offset[1] ? HALF_LO_MASK : HALF_HI_MASK;
        load_data  = '0;
        store_data = wdata;

        case (op)
            OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_data = {24'd0, byte_val};
            OP_LH:   load_data = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_data = {16'd0, half_val};
            OP_LW:   load_data = word;
            // Unaligned loads keep the rt bytes the memory word does not cover.
            OP_LWL:  load_data = (word << sh_left) | (wdata & ~(32'hFFFF_FFFF << sh_left));
            OP_LWR:  load_data = (word >> sh_right) | (wdata & ~(32'hFFFF_FFFF >> sh_right));
            default: load_data = '0;
        endcase

        case (op)
            OP_SB:   store_data = (word & ~bmask) | ({4{wdata[7:0]}} & bmask);
            OP_SH:   store_data = (word & ~hmask) | ({2{wdata[15:0]}} & hmask);
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: converts byte/half/word/unaligned accesses into word
// reads and writes on a combinational-read data memory, with fault detection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    lsu_if.slave        cpu,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        accept;
    logic        req_fault;
    logic        in_read;
    logic        in_write;
    logic [31:0] merge_word;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept = cpu.req_valid && cpu.req_ready;

    always_comb begin
        req_fault = 1'b0;
        case (cpu.req_op)
            OP_LH, OP_LHU, OP_SH:                     req_fault = cpu.req_addr[0];
            OP_LW, OP_SW:                             req_fault = |cpu.req_addr[1:0];
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB:     req_fault = 1'b0;
            default:                                  req_fault = 1'b1;
        endcase
        if (cpu.req_addr >= ADDR_LIMIT) begin
            req_fault = 1'b1;
        end
    end

    // Loads extract straight from the live read data; stores merge the captured word.
    assign merge_word = (state == ST_READ) ? mem_read_data : word_q;

    lsu_lane_merge u_lane_merge (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .word       (merge_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= cpu.req_op;
                        addr_q  <= cpu.req_addr;
                        wdata_q <= cpu.req_wdata;
                        rdata_q <= '0;
                        fault_q <= req_fault;
                        if (req_fault) begin
                            state <= ST_RESP;
                        end else if (cpu.req_op == OP_SW) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= mem_read_data;
                    if (is_store(op_q)) begin
                        state <= ST_WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: outputs are gated by reset combinationally so nothing leaks (notably a
    // write strobe) during the cycle reset is raised before the state register clears.
    assign in_read  = (state == ST_READ)  && !reset;
    assign in_write = (state == ST_WRITE) && !reset;

    assign cpu.req_ready  = (state == ST_IDLE) && !reset;
    assign cpu.resp_valid = (state == ST_RESP) && !reset;
    assign cpu.resp_fault = cpu.resp_valid && fault_q;
    assign cpu.resp_rdata = cpu.resp_valid ? rdata_q : 32'd0;

    assign mem_read       = in_read;
    assign mem_write      = in_write;
    assign mem_address    = (in_read || in_write) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = in_write ? store_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural word memory, expected
// responses queued at issue and retired by a response monitor.
module tb_load_store_unit;

    localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4,
                           LWL = 4'd5, LWR = 4'd6, OP7 = 4'd7, SB = 4'd8, SH = 4'd9, SW = 4'd10;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_idx;
    logic [31:0] pre_val;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    lsu_if bus();

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .cpu            (bus),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_address[13:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_address[13:2]] <= mem_write_data;
    end

    // Response monitor: every resp_valid must retire the oldest expectation on time.
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp at cycle %0d rdata=%h fault=%b", cyc, bus.resp_rdata, bus.resp_fault);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL resp got rdata=%h fault=%b cycle=%0d expected rdata=%h fault=%b cycle=%0d",
                             bus.resp_rdata, bus.resp_fault, cyc, e.rdata, e.fault, e.cyc);
                end
            end
        end
    end

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = byte_addr[13:2];
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Presents a request, waits for acceptance and queues the expected response.
    task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault, input int lat,
                        input bit expect_resp, input bit keep_valid, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout op=%0d addr=%h waited=%0d required<50", op, addr, waited);
        end else if (expect_resp) begin
            e.rdata = exp_rdata;
            e.fault = exp_fault;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = LW;
        bus.req_addr  = 32'h100;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, mem_read, mem_write} !== 5'b0 ||
            bus.resp_rdata !== 32'd0 || mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%b rv=%b rf=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h required all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_fault, mem_read, mem_write,
                     bus.resp_rdata, mem_address, mem_write_data);
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_loads();
        int w;
        preload(32'h104, 32'h8899AABB);
        send(LB,  32'h104, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0, w); drain();
        send(LBU, 32'h104, 32'h0, 32'h00000088, 1'b0, 2, 1, 0, w); drain();
        send(LH,  32'h106, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1, 0, w); drain();
        send(LHU, 32'h104, 32'h0, 32'h00008899, 1'b0, 2, 1, 0, w); drain();
        send(LB,  32'h107, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0, w); drain();
        send(LW,  32'h104, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0, w); drain();
    endtask

    task automatic test_sb();
        int w;
        preload(32'h100, 32'h11223344);
        send(SB, 32'h102, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1, 0, w);
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h100) begin
            n_fail++;
            $display("FAIL sb_c1 got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=00000100", mem_read, mem_write, mem_address);
        end
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== 32'h1122EF44 || mem_address !== 32'h100) begin
            n_fail++;
            $display("FAIL sb_c2 got wr=%b rd=%b wdata=%h addr=%h required wr=1 rd=0 wdata=1122ef44 addr=00000100",
                     mem_write, mem_read, mem_write_data, mem_address);
        end
        drain();
        send(LW, 32'h100, 32'h0, 32'h1122EF44, 1'b0, 2, 1, 0, w); drain();
    endtask

    task automatic test_faults();
        logic [3:0]  ops   [4] = '{LH, SW, LW, OP7};
        logic [31:0] addrs [4] = '{32'h101, 32'h102, 32'h4000, 32'h100};
        int w;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], addrs[i], 32'h12345678, 32'h0, 1'b1, 1, 1, 0, w);
            @(negedge clk);
            n_checks++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_mem_access case=%0d got rd=%b wr=%b required 0 0", i, mem_read, mem_write);
            end
            drain();
        end
    endtask

    task automatic test_unaligned();
        int w;
        preload(32'h100, 32'h11223344);
        send(LWL, 32'h101, 32'hAABBCCDD, 32'h223344DD, 1'b0, 2, 1, 0, w); drain();
        send(LWR, 32'h101, 32'hAABBCCDD, 32'hAABB1122, 1'b0, 2, 1, 0, w); drain();
        send(LWL, 32'h100, 32'hAABBCCDD, 32'h11223344, 1'b0, 2, 1, 0, w); drain();
        send(LWR, 32'h103, 32'hAABBCCDD, 32'h11223344, 1'b0, 2, 1, 0, w); drain();
    endtask

    task automatic test_reset_mid_write();
        int w;
        preload(32'h100, 32'h11223344);
        send(SH, 32'h100, 32'h0000BEEF, 32'h0, 1'b0, 3, 0, 0, w);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_write !== 1'b0 || bus.resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_write cyc=%0d got wr=%b rv=%b required 0 0", i, mem_write, bus.resp_valid);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_abort got %b required 1", bus.req_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem[12'h040] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL mem_after_abort got %h required 11223344", mem[12'h040]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        send(SW, 32'h108, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 1, w);
        send(LW, 32'h108, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 1, w);
        n_checks++;
        if (w != 2) begin
            n_fail++;
            $display("FAIL b2b_accept_wait got %0d cycles required 2", w);
        end
        bus.req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_read_state got ready=%b rd=%b required ready=0 rd=1", bus.req_ready, mem_read);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_resp_state got ready=%b rv=%b required ready=0 rv=1", bus.req_ready, bus.resp_valid);
        end
        bus.req_valid = 1'b0;
        drain();
    endtask

    initial begin
        pre_en        = 1'b0;
        pre_idx       = '0;
        pre_val       = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset         = 1'b1;
        test_reset();
        test_loads();
        test_sb();
        test_faults();
        test_unaligned();
        test_reset_mid_write();
        test_back_to_back();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations got %0d required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the CPU memory stage and the word-addressed data memory, which has a combinational read, a posedge word write and ignores address bits [1:0].
Turns MIPS byte, halfword, word and unaligned (LWL/LWR) loads and stores into word accesses, using read-modify-write for sub-word stores.
Produces sign/zero-extended and merged load results, and faults misaligned or out-of-range accesses.
Uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
ADDR_LIMIT, 32'h0000_4000, byte-address bound; req_addr >= ADDR_LIMIT faults (4096 words).

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  CPU request present
req_ready  out  1  unit can accept a request
req_op  in  4  op: LB=0 LBU=1 LH=2 LHU=3 LW=4 LWL=5 LWR=6 SB=8 SH=9 SW=10; other codes fault
req_addr  in  32  byte address
req_wdata  in  32  store data, or old rt value for LWL/LWR merge
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and faults
resp_fault  out  1  valid with resp_valid; misaligned, out-of-range or illegal op
mem_address  out  32  word-aligned byte address to data memory
mem_write_data  out  32  full word to write
mem_write  out  1  data-memory write enable
mem_read  out  1  data-memory read enable
mem_read_data  in  32  combinational read data from data memory

Behaviour:
- Reset: state=IDLE. While reset is high, every output is 0, including req_ready and mem_write.
- FSM states: IDLE, READ, WRITE, RESP. Requests are latched (op, addr, wdata) on the edge where req_valid && req_ready.
- req_ready = (state==IDLE) && !reset. req_valid is ignored in all other states.
- IDLE transitions on acceptance:
  - to RESP with fault, no memory access: fault if LH/LHU/SH with addr[0]!=0; LW/SW with addr[1:0]!=0; addr>=ADDR_LIMIT; or illegal op. LWL, LWR, LB, LBU and SB never fault on alignment.
  - to WRITE: SW.
  - to READ: all other ops.
- READ state:
  - Drives mem_read=1, mem_address={addr[31:2],2'b00}.
  - Captures mem_read_data into the word register at the edge.
  - Loads then go to RESP; SB/SH go to WRITE.
- WRITE state:
  - Drives mem_write=1 (gated by !reset), same mem_address, merged word.
  - Then goes to RESP.
- RESP state:
  - resp_valid=1 for exactly one cycle, with resp_rdata and resp_fault.
  - Then returns to IDLE; a new request can be accepted in the next cycle.
- Outside READ/WRITE: mem_address, mem_write_data, mem_read and mem_write are all 0.
- Latency, with C0 as the acceptance cycle, resp_valid asserts in:
  - C2 for loads and SW;
  - C3 for SB/SH;
  - C1 for faults.
- Endianness is big-endian. Byte offset k=addr[1:0] maps to lane bits [31-8k -: 8]. Halfword offset 0 is [31:16]; offset 2 is [15:0].
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- LWL: (word << 8k) | (rt & ((1<<8k)-1)).
- LWR: (word >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k))).
- Store merge:
  - SB replaces lane k with wdata[7:0].
  - SH replaces the selected half with wdata[15:0].
  - SW writes wdata unchanged.
- Reset mid-operation:
  - Aborts the operation; no write is issued on any edge where reset is high.
  - Memory is unchanged and no response is produced.

Decomposition:
- Package lsu_pkg holds:
  - the op enum (codes above) and the state enum;
  - the lane and halfword select constants;
  - an is_store(op) function.
- One combinational sub-module, lsu_lane_merge:
  - Inputs: op, offset, memory word, wdata/rt.
  - Outputs: the load result and the merged store word.
  - Keeps the FSM free of datapath.

Test Plan:
1. Preload mem[0x104]=0x8899AABB. Check each request:
   - LB 0x104 -> resp_rdata 0xFFFFFF88.
   - LBU 0x104 -> 0x00000088.
   - LH 0x106 -> 0xFFFFAABB.
   - All: resp_valid in C2, fault 0.
2. Preload mem[0x100]=0x11223344. SB 0x102, wdata 0xDEADBEEF:
   - C1: mem_read=1.
   - C2: mem_write=1, mem_write_data 0x1122EF44.
   - C3: resp_valid.
   - Then LW 0x100 -> 0x1122EF44.
3. Faults, each with no mem_read or mem_write and resp_valid in C1:
   - LH 0x101 -> resp_fault=1.
   - SW 0x102 -> resp_fault=1.
   - LW 0x4000 -> resp_fault=1.
   - op 7 -> resp_fault=1.
4. mem[0x100]=0x11223344, rt=0xAABBCCDD:
   - LWL 0x101 -> 0x223344DD.
   - LWR 0x101 -> 0xAABB1122.
   - LWL 0x100 -> 0x11223344.
   - LWR 0x103 -> 0x11223344.
5. SH 0x100, wdata 0x0000BEEF, with reset asserted during WRITE:
   - mem_write stays 0 and mem[0x100] is unchanged.
   - No resp_valid.
   - req_ready=1 in the first cycle after reset deasserts.
6. Hold req_valid high with a back-to-back SW 0x108 then LW 0x108:
   - Second request accepted only in the cycle after RESP.
   - LW returns the stored value; req_ready is low in WRITE, READ and RESP.
